// File: rtl/nes_pkg.sv
// Shared NES pad definitions: responder FSM states and button bit positions.
// Used by both the controller responder and the console-side receiver.
package nes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } nes_resp_state_t;

    // Position of each button in the parallel word; bit 7 is sent first.
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    localparam int NES_WIDTH = 8;

endpackage

// File: rtl/nes_controller_responder_if.sv
// NES connector pins: console drives latch/pulse, pad answers on data.
// master = console side, slave = pad (responder) side.
interface nes_controller_responder_if;

    logic nes_latch;
    logic nes_pulse;
    logic nes_data;

    modport master (
        output nes_latch,
        output nes_pulse,
        input  nes_data
    );

    modport slave (
        input  nes_latch,
        input  nes_pulse,
        output nes_data
    );

endinterface

// File: rtl/nes_sync_edge.sv
// Synchroniser for an asynchronous pin plus a prev flop for edge detection.
// Ports: clk, rst (async high), i_pin; o_level, o_rise, o_fall (all synchronous).
module nes_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/nes_controller_responder.sv
// Emulates the 4021 shift register in an NES pad: latch loads buttons, pulse shifts.
// Ports: clock_12MHz, reset, nes (latch/pulse/data pins), buttons, bit_index, frame_done, busy.
module nes_controller_responder
    import nes_pkg::*;
#(
    parameter  int WIDTH       = NES_WIDTH,
    parameter  int SYNC_STAGES = 2,
    localparam int IW          = $clog2(WIDTH + 1)
) (
    input  logic                   clock_12MHz,
    input  logic                   reset,
    nes_controller_responder_if.slave nes,
    input  logic [WIDTH-1:0]       buttons,
    output logic [IW-1:0]          bit_index,
    output logic                   frame_done,
    output logic                   busy
);

    logic w_latch_level;
    logic w_latch_rise;
    logic w_latch_fall;
    logic w_pulse_level;
    logic w_pulse_rise;
    logic w_pulse_fall;
    logic w_unused;

    nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk     (clock_12MHz),
        .rst     (reset),
        .i_pin   (nes.nes_latch),
        .o_level (w_latch_level),
        .o_rise  (w_latch_rise),
        .o_fall  (w_latch_fall)
    );

    nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
        .clk     (clock_12MHz),
        .rst     (reset),
        .i_pin   (nes.nes_pulse),
        .o_level (w_pulse_level),
        .o_rise  (w_pulse_rise),
        .o_fall  (w_pulse_fall)
    );

    // Only the pulse rising edge matters to the shifter.
    assign w_unused = &{1'b0, w_pulse_level, w_pulse_fall};

    nes_resp_state_t  r_state;
    logic [WIDTH-1:0] r_shift;
    logic [IW-1:0]    r_bit_index;
    logic             r_frame_done;
    logic [IW-1:0]    w_idx_next;

    assign w_idx_next = r_bit_index + IW'(1);

    always_ff @(posedge clock_12MHz or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_index  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_latch_level) begin
                        r_state     <= LOAD;
                        r_shift     <= buttons;
                        r_bit_index <= '0;
                    end
                end
                LOAD: begin
                    // Transparent load while latch is held, like the 4021.
                    r_shift     <= buttons;
                    r_bit_index <= '0;
                    if (w_latch_fall) begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A latch rise aborts the frame and beats a coincident pulse.
                    if (w_latch_rise) begin
                        r_state     <= LOAD;
                        r_shift     <= buttons;
                        r_bit_index <= '0;
                    end else if (w_pulse_rise) begin
                        r_shift     <= {r_shift[WIDTH-2:0], 1'b0};
                        r_bit_index <= w_idx_next;
                        if (w_idx_next == IW'(WIDTH)) begin
                            r_state      <= DONE;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Zeros keep shifting in, so data stays high; index saturates.
                    if (w_latch_rise) begin
                        r_state     <= LOAD;
                        r_shift     <= buttons;
                        r_bit_index <= '0;
                    end else if (w_pulse_rise) begin
                        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    end
                end
            endcase
        end
    end

    assign nes.nes_data = ~r_shift[WIDTH-1];
    assign bit_index    = r_bit_index;
    assign frame_done   = r_frame_done;
    assign busy         = (r_state == LOAD) || (r_state == SHIFT);

endmodule

// File: tb/tb_nes_controller_responder.sv
// Directed bench for the NES controller responder.
// Drives pins on the falling clock edge and samples outputs there too.
module tb_nes_controller_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] buttons;
    logic [3:0] bit_index;
    logic       frame_done;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;
    int fd_cnt   = 0;
    int fd0;
    logic [7:0] b;

    nes_controller_responder_if nes ();

    nes_controller_responder #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clock_12MHz (clk),
        .reset       (rst),
        .nes         (nes),
        .buttons     (buttons),
        .bit_index   (bit_index),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #42 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nes.nes_latch = 1'b0;
        nes.nes_pulse = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    // 12 us latch, then let the fall reach the FSM.
    task automatic do_latch();
        nes.nes_latch = 1'b1;
        tick(143);
        nes.nes_latch = 1'b0;
        tick(4);
    endtask

    // 6 us pulse period, 50% duty.
    task automatic do_pulse();
        nes.nes_pulse = 1'b1;
        tick(36);
        nes.nes_pulse = 1'b0;
        tick(36);
    endtask

    initial begin
        rst = 1'b1;
        nes.nes_latch = 1'b0;
        nes.nes_pulse = 1'b0;
        buttons = 8'h00;
        #1;
        check_eq("rst_data", nes.nes_data, 1'b1);
        check_eq("rst_idx", bit_index, 4'd0);
        check_eq("rst_fd", frame_done, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Latch and pulse rise together: no shift.
        buttons = 8'h80;
        nes.nes_latch = 1'b1;
        nes.nes_pulse = 1'b1;
        tick(3);
        check_eq("same_busy", busy, 1'b1);
        check_eq("same_idx", bit_index, 4'd0);
        check_eq("same_data", nes.nes_data, 1'b0);
        buttons = 8'h00;
        tick(1);
        check_eq("load_transparent", nes.nes_data, 1'b1);
        nes.nes_latch = 1'b0;
        tick(4);
        check_eq("same_shift_busy", busy, 1'b1);
        check_eq("same_shift_idx", bit_index, 4'd0);
        nes.nes_pulse = 1'b0;
        tick(4);
        check_eq("held_pulse_idx", bit_index, 4'd0);
        do_pulse();
        check_eq("later_pulse_idx", bit_index, 4'd1);

        // Latency: data shows ~buttons[7] on the third edge.
        do_reset();
        buttons = 8'h80;
        nes.nes_latch = 1'b1;
        tick(2);
        check_eq("lat_edge2", nes.nes_data, 1'b1);
        tick(1);
        check_eq("lat_edge3", nes.nes_data, 1'b0);
        check_eq("lat_busy", busy, 1'b1);
        nes.nes_latch = 1'b0;
        tick(4);

        // Asynchronous reset mid-SHIFT.
        buttons = 8'hFF;
        do_latch();
        for (int k = 0; k < 3; k++) do_pulse();
        check_eq("pre_rst_idx", bit_index, 4'd3);
        check_eq("pre_rst_data", nes.nes_data, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_data", nes.nes_data, 1'b1);
        check_eq("mid_rst_idx", bit_index, 4'd0);
        check_eq("mid_rst_busy", busy, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Full frame with A and Right pressed.
        b = 8'b1000_0001;
        buttons = b;
        fd0 = fd_cnt;
        do_latch();
        check_eq("f2_data0", nes.nes_data, 1'b0);
        check_eq("f2_idx0", bit_index, 4'd0);
        for (int k = 1; k <= 8; k++) begin
            do_pulse();
            check_eq($sformatf("f2_data%0d", k), nes.nes_data,
                     (k < 8) ? {31'd0, ~b[7-k]} : 32'd1);
            check_eq($sformatf("f2_idx%0d", k), bit_index, k);
        end
        check_eq("f2_fd_count", fd_cnt - fd0, 1);
        check_eq("f2_busy", busy, 1'b0);

        // Ten pulses with every button pressed.
        buttons = 8'hFF;
        fd0 = fd_cnt;
        do_latch();
        check_eq("f4_data0", nes.nes_data, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            do_pulse();
            check_eq($sformatf("f4_data%0d", k), nes.nes_data,
                     (k < 8) ? 32'd0 : 32'd1);
        end
        check_eq("f4_idx_sat", bit_index, 4'd8);
        check_eq("f4_fd_count", fd_cnt - fd0, 1);

        // Aborted frame: relatch after four pulses with buttons released.
        buttons = 8'hFF;
        fd0 = fd_cnt;
        do_latch();
        for (int k = 0; k < 4; k++) do_pulse();
        check_eq("f5_idx4", bit_index, 4'd4);
        buttons = 8'h00;
        tick(4);
        check_eq("f5_btn_ignored", nes.nes_data, 1'b0);
        nes.nes_latch = 1'b1;
        tick(3);
        check_eq("f5_load_data", nes.nes_data, 1'b1);
        check_eq("f5_load_idx", bit_index, 4'd0);
        check_eq("f5_load_busy", busy, 1'b1);
        nes.nes_latch = 1'b0;
        tick(4);
        check_eq("f5_no_fd", fd_cnt - fd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
